mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Parametrised N-channel memory request arbiter that merges the CPU-side instruction-read, data-read and data-write request channels, plus optional extra masters such as a DMA engine or a second core, onto the single shared memory port (`read_req`/`write_req`, `read_valid`/`write_finish`). It sits between the CPU stages and the memory controller. It replaces the implicit one-request-at-a-time sharing of `read_valid`/`read_data` with:

- explicit grant arbitration, fixed-priority or round-robin;
- per-channel completion pulses;
- a response timeout that reports an error.

## Interface
Parameters:
- `NCH`, 3: number of request channels (1–8).
- `AW`, 32: address width.
- `DW`, 32: data width.
- `RR_MODE`, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- `TIMEOUT`, 255: maximum BUSY cycles before abort. 0 disables the timeout.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `ch_req` in NCH: per-channel request. Level signal; held until that channel's `ch_done`.
- `ch_we` in NCH: 1 = write, 0 = read.
- `ch_w` in NCH: word access.
- `ch_hw` in NCH: halfword access. If both `ch_w` and `ch_hw` are 0, the access is a byte access.
- `ch_adr` in NCH*AW: channel addresses, flattened; channel i is at [i*AW +: AW].
- `ch_wdata` in NCH*DW: write data, flattened the same way.
- `ch_done` out NCH: one-cycle completion pulse for the granted channel.
- `ch_err` out NCH: one-cycle pulse, coincident with `ch_done`, when the access timed out.
- `ch_rdata` out DW: read data of the last completed read.
- `read_req` out 1: downstream read request.
- `write_req` out 1: downstream write request.
- `m_w` out 1, `m_hw` out 1: downstream access size.
- `m_adr` out AW: downstream address.
- `m_wdata` out DW: downstream write data.
- `read_valid` in 1: downstream read response, one-cycle pulse.
- `read_data` in DW: downstream read data, sampled when `read_valid` = 1.
- `write_finish` in 1: downstream write completion, one-cycle pulse.
- `grant_id` out clog2(NCH), minimum 1 bit: index of the channel currently or last granted.
- `spurious_rsp` out 1: sticky flag, set when a response arrives outside BUSY.

## Operation
State machine: IDLE → BUSY → DONE → IDLE.

IDLE:
- If any `ch_req` bit is set, select a winner:
  - RR_MODE = 0: lowest index with `ch_req` set.
  - RR_MODE = 1: first index with `ch_req` set, searching upward from `rr_ptr` with wrap-around modulo NCH.
- Register `grant_id` and the winner's `we`/`w`/`hw`/`adr`/`wdata` into the `m_*` outputs.
- Assert `read_req` or `write_req` according to the registered `we`.
- Clear the timeout counter and go to BUSY.

BUSY:
- `read_req`/`write_req` stay high and `m_*` stay stable.
- Read grant, `read_valid` = 1: capture `read_data` into `ch_rdata`, pulse `ch_done[grant_id]`, drop the request, go to DONE.
- Write grant, `write_finish` = 1: pulse `ch_done[grant_id]` without touching `ch_rdata`, drop the request, go to DONE.
- A response that does not match the granted type (for example `write_finish` during a read) is ignored and sets `spurious_rsp`.
- Timeout: the counter increments every BUSY cycle. With TIMEOUT ≠ 0, when the counter reaches TIMEOUT with no response:
  - pulse `ch_done` and `ch_err` for `grant_id`;
  - load `ch_rdata` = 0 if the access was a read;
  - drop the request and go to DONE.
- A response arriving in the same cycle the counter reaches TIMEOUT wins: normal completion, no `ch_err`.

DONE:
- Single gap cycle so the completed channel can drop `ch_req`. No arbitration takes place in DONE.
- Set `rr_ptr` = (`grant_id` + 1) mod NCH, then go to IDLE.

Other rules:
- `read_valid` or `write_finish` in IDLE or DONE sets `spurious_rsp`; no other effect.
- A channel that drops `ch_req` while granted does not cancel the access: the access completes and `ch_done` still pulses.
- Reset mid-access: all state is cleared immediately and the downstream request drops asynchronously. The memory side must tolerate the abandoned request.

## Timing
Reset values:
- state IDLE;
- `read_req`, `write_req`, `m_w`, `m_hw` = 0; `m_adr`, `m_wdata` = 0;
- `ch_done`, `ch_err` = 0; `ch_rdata` = 0;
- `grant_id` = 0, `rr_ptr` = 0, `spurious_rsp` = 0.

All outputs are registered. No combinational path from inputs to outputs.

Latency:
- `ch_req` sampled in IDLE at cycle 0 → downstream request high in cycle 1.
- Response at cycle k (k ≥ 1) → `ch_done` and `ch_rdata` valid in cycle k+1, with the request low in that same cycle.
- DONE occupies cycle k+1; the next grant is at the earliest in cycle k+2 (IDLE), with its request high in cycle k+3.
- Minimum back-to-back pitch: 3 cycles plus memory latency.
- Timeout: `ch_err` is pulsed TIMEOUT+1 cycles after the request rises.

Counter width is clog2(TIMEOUT+1) and the counter saturates; it never wraps.

`ch_rdata` holds its value until the next read completion or read timeout.

## Test plan
- Reset, then idle 10 cycles: all outputs 0; `read_valid` pulse → `spurious_rsp` = 1, nothing else changes.
- NCH=3, RR_MODE=0; ch1 read adr 0x100, memory returns 0xDEADBEEF after 4 cycles → `read_req` high in cycles 1–4, `ch_done[1]` pulse in cycle 5, `ch_rdata` = 0xDEADBEEF, `grant_id` = 1.
- RR_MODE=0; ch0 and ch2 request simultaneously and continuously → ch0 is served repeatedly and ch2 starves; RR_MODE=1, same stimulus → grants alternate 0, 2, 0, 2.
- TIMEOUT=8; ch0 write, no `write_finish` → `ch_done[0]` and `ch_err[0]` pulse together 9 cycles after `write_req` rises, `write_req` low from then on; FSM returns to IDLE.
- Response in the same cycle the counter reaches TIMEOUT → normal completion, `ch_err` = 0.
- `rst_n` asserted during BUSY → `read_req` falls without waiting for a clock edge and no `ch_done` pulses; after release, a new request is served normally.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// N-channel request arbiter onto a single shared memory port, with fixed-priority or
// round-robin grant, per-channel completion pulses and a response timeout.
module mem_bus_arbiter #(
  parameter int unsigned NCH     = 3,
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned RR_MODE = 0,
  parameter int unsigned TIMEOUT = 255,
  localparam int unsigned GW     = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int unsigned CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_we,
  input  logic [NCH-1:0]    ch_w,
  input  logic [NCH-1:0]    ch_hw,
  input  logic [NCH*AW-1:0] ch_adr,
  input  logic [NCH*DW-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_done,
  output logic [NCH-1:0]    ch_err,
  output logic [DW-1:0]     ch_rdata,
  output logic              read_req,
  output logic              write_req,
  output logic              m_w,
  output logic              m_hw,
  output logic [AW-1:0]     m_adr,
  output logic [DW-1:0]     m_wdata,
  input  logic              read_valid,
  input  logic [DW-1:0]     read_data,
  input  logic              write_finish,
  output logic [GW-1:0]     grant_id,
  output logic              spurious_rsp
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [GW-1:0]  grant_q, grant_d, rr_ptr_q, rr_ptr_d, winner;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           read_req_q, read_req_d, write_req_q, write_req_d;
  logic           m_w_q, m_w_d, m_hw_q, m_hw_d, spur_q, spur_d;
  logic [AW-1:0]  m_adr_q, m_adr_d;
  logic [DW-1:0]  m_wdata_q, m_wdata_d, rdata_q, rdata_d;
  logic [NCH-1:0] done_q, done_d, err_q, err_d;
  logic           got_rsp, wrong_rsp, timed_out;

  // Fixed priority scans from index 0; round-robin scans upward from ptr with wrap.
  function automatic logic [GW-1:0] pick(input logic [NCH-1:0] req, input logic [GW-1:0] ptr);
    logic [GW-1:0] sel, idx;
    logic          found;
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = GW'((RR_MODE != 0) ? (32'(ptr) + i) % NCH : i);
      if (!found && req[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
    return sel;
  endfunction

  assign winner    = pick(ch_req, rr_ptr_q);
  assign got_rsp   = read_req_q ? read_valid : write_finish;
  assign wrong_rsp = read_req_q ? write_finish : read_valid;
  assign timed_out = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT));

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    cnt_d       = cnt_q;
    read_req_d  = read_req_q;
    write_req_d = write_req_q;
    m_w_d       = m_w_q;
    m_hw_d      = m_hw_q;
    m_adr_d     = m_adr_q;
    m_wdata_d   = m_wdata_q;
    rdata_d     = rdata_q;
    spur_d      = spur_q;
    done_d      = '0;
    err_d       = '0;
    case (state_q)
      StIdle: begin
        if (read_valid || write_finish) spur_d = 1'b1;
        if (|ch_req) begin
          grant_d     = winner;
          m_w_d       = ch_w[winner];
          m_hw_d      = ch_hw[winner];
          m_adr_d     = ch_adr[winner*AW +: AW];
          m_wdata_d   = ch_wdata[winner*DW +: DW];
          read_req_d  = ~ch_we[winner];
          write_req_d = ch_we[winner];
          cnt_d       = '0;
          state_d     = StBusy;
        end
      end
      StBusy: begin
        if (wrong_rsp) spur_d = 1'b1;
        if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
        // A response in the timeout cycle takes precedence over the abort.
        if (got_rsp || timed_out) begin
          done_d[grant_q] = 1'b1;
          err_d[grant_q]  = ~got_rsp;
          if (read_req_q) rdata_d = got_rsp ? read_data : '0;
          read_req_d  = 1'b0;
          write_req_d = 1'b0;
          state_d     = StDone;
        end
      end
      StDone: begin
        if (read_valid || write_finish) spur_d = 1'b1;
        rr_ptr_d = GW'((32'(grant_q) + 32'd1) % NCH);
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      grant_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      read_req_q  <= 1'b0;
      write_req_q <= 1'b0;
      m_w_q       <= 1'b0;
      m_hw_q      <= 1'b0;
      m_adr_q     <= '0;
      m_wdata_q   <= '0;
      rdata_q     <= '0;
      spur_q      <= 1'b0;
      done_q      <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      cnt_q       <= cnt_d;
      read_req_q  <= read_req_d;
      write_req_q <= write_req_d;
      m_w_q       <= m_w_d;
      m_hw_q      <= m_hw_d;
      m_adr_q     <= m_adr_d;
      m_wdata_q   <= m_wdata_d;
      rdata_q     <= rdata_d;
      spur_q      <= spur_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign ch_done      = done_q;
  assign ch_err       = err_q;
  assign ch_rdata     = rdata_q;
  assign read_req     = read_req_q;
  assign write_req    = write_req_q;
  assign m_w          = m_w_q;
  assign m_hw         = m_hw_q;
  assign m_adr        = m_adr_q;
  assign m_wdata      = m_wdata_q;
  assign grant_id     = grant_q;
  assign spurious_rsp = spur_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: instance 0 is fixed priority, instance 1 round-robin, both
// TIMEOUT=8. Completions are checked by a scoreboard monitor against pushed expectations.
module tb_mem_bus_arbiter;

  typedef struct packed {
    logic [2:0]  done;
    logic [2:0]  err;
    logic [1:0]  gid;
    logic [31:0] rdata;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  ch_req[2], ch_we[2], ch_w[2], ch_hw[2], ch_done[2], ch_err[2];
  logic [95:0] ch_adr[2], ch_wdata[2];
  logic [31:0] ch_rdata[2], m_adr[2], m_wdata[2], read_data[2];
  logic        read_req[2], write_req[2], m_w[2], m_hw[2];
  logic        read_valid[2], write_finish[2], spurious_rsp[2];
  logic [1:0]  grant_id[2];

  int          checks = 0;
  int          errors = 0;
  exp_t        sb0[$];
  exp_t        sb1[$];
  logic [31:0] last_rd[2];

  always #5 clk = ~clk;

  mem_bus_arbiter #(.NCH(3), .AW(32), .DW(32), .RR_MODE(0), .TIMEOUT(8)) dut_fp (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req[0]), .ch_we(ch_we[0]), .ch_w(ch_w[0]),
    .ch_hw(ch_hw[0]), .ch_adr(ch_adr[0]), .ch_wdata(ch_wdata[0]), .ch_done(ch_done[0]),
    .ch_err(ch_err[0]), .ch_rdata(ch_rdata[0]), .read_req(read_req[0]),
    .write_req(write_req[0]), .m_w(m_w[0]), .m_hw(m_hw[0]), .m_adr(m_adr[0]),
    .m_wdata(m_wdata[0]), .read_valid(read_valid[0]), .read_data(read_data[0]),
    .write_finish(write_finish[0]), .grant_id(grant_id[0]), .spurious_rsp(spurious_rsp[0])
  );

  mem_bus_arbiter #(.NCH(3), .AW(32), .DW(32), .RR_MODE(1), .TIMEOUT(8)) dut_rr (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req[1]), .ch_we(ch_we[1]), .ch_w(ch_w[1]),
    .ch_hw(ch_hw[1]), .ch_adr(ch_adr[1]), .ch_wdata(ch_wdata[1]), .ch_done(ch_done[1]),
    .ch_err(ch_err[1]), .ch_rdata(ch_rdata[1]), .read_req(read_req[1]),
    .write_req(write_req[1]), .m_w(m_w[1]), .m_hw(m_hw[1]), .m_adr(m_adr[1]),
    .m_wdata(m_wdata[1]), .read_valid(read_valid[1]), .read_data(read_data[1]),
    .write_finish(write_finish[1]), .grant_id(grant_id[1]), .spurious_rsp(spurious_rsp[1])
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  task automatic push(input int d, input int c, input bit err, input logic [31:0] rdata);
    exp_t e;
    e.done  = 3'b001 << c;
    e.err   = err ? (3'b001 << c) : 3'b000;
    e.gid   = 2'(c);
    e.rdata = rdata;
    if (d == 0) sb0.push_back(e);
    else sb1.push_back(e);
  endtask

  task automatic mon_cmp(input int d, input exp_t e);
    exp_t a;
    a = '{done: ch_done[d], err: ch_err[d], gid: grant_id[d], rdata: ch_rdata[d]};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL completion dut%0d: got done=%b err=%b gid=%0d rdata=0x%0h required done=%b err=%b gid=%0d rdata=0x%0h",
               d, a.done, a.err, a.gid, a.rdata, e.done, e.err, e.gid, e.rdata);
    end
  endtask

  always @(negedge clk) begin
    if (ch_done[0] !== 3'b000 || ch_err[0] !== 3'b000) begin
      if (sb0.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done dut0: got done=%b err=%b required none", ch_done[0], ch_err[0]);
      end else mon_cmp(0, sb0.pop_front());
    end
    if (ch_done[1] !== 3'b000 || ch_err[1] !== 3'b000) begin
      if (sb1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done dut1: got done=%b err=%b required none", ch_done[1], ch_err[1]);
      end else mon_cmp(1, sb1.pop_front());
    end
  end

  task automatic set_ch(input int d, input int c, input bit we, input bit w, input bit hw,
                        input logic [31:0] adr, input logic [31:0] wd);
    ch_we[d][c] = we;
    ch_w[d][c]  = w;
    ch_hw[d][c] = hw;
    ch_adr[d][c*32 +: 32]   = adr;
    ch_wdata[d][c*32 +: 32] = wd;
  endtask

  // Wait for the downstream request, then respond after lat cycles of it being high.
  task automatic serve(input int d, input bit is_wr, input logic [31:0] data, input int lat);
    int n = 0;
    while (((is_wr ? write_req[d] : read_req[d]) !== 1'b1) && n < 20) begin
      tick;
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL serve_wait dut%0d: request got 0 required 1 within 20 cycles", d);
      return;
    end
    repeat (lat - 1) tick;
    if (is_wr) write_finish[d] = 1'b1;
    else begin
      read_valid[d] = 1'b1;
      read_data[d]  = data;
    end
    tick;
    write_finish[d] = 1'b0;
    read_valid[d]   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      ch_req[d] = '0; ch_we[d] = '0; ch_w[d] = '0; ch_hw[d] = '0;
      ch_adr[d] = '0; ch_wdata[d] = '0; read_data[d] = '0;
      read_valid[d] = 1'b0; write_finish[d] = 1'b0; last_rd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) tick;

    check("rst_ctl", {28'd0, read_req[0], write_req[0], m_w[0], m_hw[0]}, 32'd0);
    check("rst_adr", m_adr[0], 32'd0);
    check("rst_wdata", m_wdata[0], 32'd0);
    check("rst_rdata", ch_rdata[0], 32'd0);
    check("rst_flags", {23'd0, ch_done[0], ch_err[0], grant_id[0], spurious_rsp[0]}, 32'd0);

    // Response while idle only raises the sticky flag.
    read_valid[0] = 1'b1;
    read_data[0]  = 32'h1234_5678;
    tick;
    read_valid[0] = 1'b0;
    tick;
    check("spur_set", {31'd0, spurious_rsp[0]}, 32'd1);
    check("spur_rdata", ch_rdata[0], 32'd0);
    check("spur_req", {31'd0, read_req[0]}, 32'd0);

    // ch1 word read, response in cycle 4.
    set_ch(0, 1, 1'b0, 1'b1, 1'b0, 32'h100, 32'h0);
    ch_req[0] = 3'b010;
    push(0, 1, 1'b0, 32'hDEAD_BEEF);
    last_rd[0] = 32'hDEAD_BEEF;
    tick;
    check("rd_adr", m_adr[0], 32'h100);
    check("rd_gid", {30'd0, grant_id[0]}, 32'd1);
    check("rd_size", {30'd0, m_w[0], m_hw[0]}, 32'b10);
    for (int c = 1; c <= 4; c++) begin
      check("rd_req_hi", {31'd0, read_req[0]}, 32'd1);
      if (c == 4) begin
        read_valid[0] = 1'b1;
        read_data[0]  = 32'hDEAD_BEEF;
      end
      tick;
    end
    read_valid[0] = 1'b0;
    check("rd_req_lo", {31'd0, read_req[0]}, 32'd0);
    check("rd_done", {29'd0, ch_done[0]}, 32'b010);
    check("rd_data", ch_rdata[0], 32'hDEAD_BEEF);
    ch_req[0] = '0;
    tick;

    // ch1 halfword write; ch_rdata must not change.
    set_ch(0, 1, 1'b1, 1'b0, 1'b1, 32'h204, 32'h0000_A5A5);
    ch_req[0] = 3'b010;
    push(0, 1, 1'b0, last_rd[0]);
    tick;
    check("wr_ctl", {28'd0, read_req[0], write_req[0], m_w[0], m_hw[0]}, 32'b0101);
    check("wr_wdata", m_wdata[0], 32'h0000_A5A5);
    serve(0, 1'b1, 32'h0, 1);
    ch_req[0] = '0;
    tick;

    // Fixed priority: ch0 and ch2 held, ch0 wins every time.
    set_ch(0, 0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_ch(0, 2, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    ch_req[0] = 3'b101;
    for (int i = 0; i < 3; i++) begin
      push(0, 0, 1'b0, 32'h1111_0000 + i);
      serve(0, 1'b0, 32'h1111_0000 + i, 2);
    end
    last_rd[0] = 32'h1111_0002;
    ch_req[0] = '0;
    tick;

    // Round-robin on the second instance: 0, 2, 0, 2.
    set_ch(1, 0, 1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_ch(1, 2, 1'b0, 1'b1, 1'b0, 32'h20, 32'h0);
    ch_req[1] = 3'b101;
    for (int i = 0; i < 4; i++) begin
      push(1, (i % 2 == 0) ? 0 : 2, 1'b0, 32'hB000_0000 + i);
      serve(1, 1'b0, 32'hB000_0000 + i, 1);
    end
    ch_req[1] = '0;
    tick;

    // Write timeout: request high cycles 1..9, done+err in cycle 10.
    set_ch(0, 0, 1'b1, 1'b1, 1'b0, 32'h300, 32'h55);
    ch_req[0] = 3'b001;
    push(0, 0, 1'b1, last_rd[0]);
    tick;
    check("to_wdata", m_wdata[0], 32'h55);
    for (int c = 1; c <= 9; c++) begin
      check("to_req_hi", {29'd0, ch_err[0], write_req[0]}, 32'd1);
      tick;
    end
    check("to_err", {26'd0, ch_done[0], ch_err[0]}, {26'd0, 3'b001, 3'b001});
    check("to_req_lo", {31'd0, write_req[0]}, 32'd0);
    ch_req[0] = '0;
    tick;
    tick;
    check("to_idle", {30'd0, read_req[0], write_req[0]}, 32'd0);

    // Response exactly at the timeout cycle completes normally.
    set_ch(0, 2, 1'b0, 1'b1, 1'b0, 32'h400, 32'h0);
    ch_req[0] = 3'b100;
    push(0, 2, 1'b0, 32'hC0FF_EE01);
    serve(0, 1'b0, 32'hC0FF_EE01, 9);
    check("tie_err", {29'd0, ch_err[0]}, 32'd0);
    check("tie_data", ch_rdata[0], 32'hC0FF_EE01);
    ch_req[0] = '0;
    tick;

    // Read timeout clears ch_rdata.
    set_ch(0, 1, 1'b0, 1'b0, 1'b0, 32'h500, 32'h0);
    ch_req[0] = 3'b010;
    push(0, 1, 1'b1, 32'h0);
    repeat (10) tick;
    check("rdto_data", ch_rdata[0], 32'h0);
    ch_req[0] = '0;
    tick;

    // Asynchronous reset in the middle of a read.
    set_ch(0, 0, 1'b0, 1'b1, 1'b0, 32'h600, 32'h0);
    ch_req[0] = 3'b001;
    tick;
    tick;
    check("arst_pre", {31'd0, read_req[0]}, 32'd1);
    #2 rst_n = 1'b0;
    ch_req[0] = '0;
    #1;
    check("arst_req", {31'd0, read_req[0]}, 32'd0);
    check("arst_adr", m_adr[0], 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    check("arst_spur", {31'd0, spurious_rsp[0]}, 32'd0);

    // After reset: new read, with a mismatched write_finish ignored mid-access.
    set_ch(0, 2, 1'b0, 1'b1, 1'b0, 32'h700, 32'h0);
    ch_req[0] = 3'b100;
    push(0, 2, 1'b0, 32'h77);
    tick;
    write_finish[0] = 1'b1;
    tick;
    write_finish[0] = 1'b0;
    check("mm_spur", {31'd0, spurious_rsp[0]}, 32'd1);
    check("mm_req", {31'd0, read_req[0]}, 32'd1);
    read_valid[0] = 1'b1;
    read_data[0]  = 32'h77;
    tick;
    read_valid[0] = 1'b0;
    check("post_rst_data", ch_rdata[0], 32'h77);
    ch_req[0] = '0;
    repeat (3) tick;

    check("sb0_empty", sb0.size(), 32'd0);
    check("sb1_empty", sb1.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
